jpeg_bit_packer: RTL and testbench

- Entropy-stream packer placed after the Huffman encoder in the JPEG pipeline.
- Accepts variable-length codes of up to `MAX_CODE_W` bits per beat and concatenates them MSB-first into a byte stream with JPEG 0xFF→0xFF 0x00 byte stuffing.
- On request, pads the final byte with 1s and marks the last byte.
- Generalises the earlier fixed 16-bit/4-bit-length code output:
  - parametrised code width;
  - valid/ready backpressure on both sides;
  - flush and end-of-image signalling.

---
 rtl/jpeg_bit_packer.sv | 134 +++++++++++++
 tb/tb_jpeg_bit_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bit_packer.sv
// JPEG entropy-stream bit packer: concatenates variable-length codes MSB-first
// into bytes, inserts 0x00 after every 0xFF, and 1-pads/marks the final byte on flush.
module jpeg_bit_packer #(
  parameter int MAX_CODE_W = 32,
  parameter int LEN_W      = $clog2(MAX_CODE_W + 1),
  parameter int ACC_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MAX_CODE_W-1:0] in_code,
  input  logic [LEN_W-1:0]      in_len,
  input  logic                  in_flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_byte,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done
);
  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {RUN, PAD, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stuff_pend_q, stuff_pend_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_c;
  logic             accept, out_free, extract, final_c, drained;
  logic [2:0]       pad_len;
  logic [7:0]       top;
  logic [ACC_W-1:0] acc_base, app_vec;
  logic [CNT_W-1:0] cnt_base, app_len;

  assign in_ready = (state_q == RUN) && (cnt_q <= CNT_W'(ACC_W - MAX_CODE_W));

  always_comb begin
    len_c    = (in_len > LEN_W'(MAX_CODE_W)) ? LEN_W'(MAX_CODE_W) : in_len;
    accept   = in_valid && in_ready;
    out_free = !out_valid_q || out_ready;
    top      = acc_q[ACC_W-1 -: 8];
    pad_len  = ~cnt_q[2:0] + 3'd1;
    extract  = out_free && !stuff_pend_q && (cnt_q >= CNT_W'(8));

    // Extraction and append share a cycle: append lands below the post-shift count.
    acc_base = extract ? (acc_q << 8) : acc_q;
    cnt_base = extract ? (cnt_q - CNT_W'(8)) : cnt_q;
    app_vec  = '0;
    app_len  = '0;
    if (accept) begin
      app_vec = ACC_W'(in_code & ~({MAX_CODE_W{1'b1}} << len_c));
      app_len = CNT_W'(len_c);
    end else if (state_q == PAD) begin
      app_vec = ~({ACC_W{1'b1}} << pad_len);
      app_len = CNT_W'(pad_len);
    end
    acc_d = acc_base | (app_vec << (CNT_W'(ACC_W) - cnt_base - app_len));
    cnt_d = cnt_base + app_len;

    // A loaded byte is last when no more image bits can follow it.
    final_c      = (state_q != RUN) || (accept && in_flush);
    stuff_pend_d = stuff_pend_q;
    out_byte_d   = out_byte_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    if (out_free) begin
      if (stuff_pend_q) begin
        out_byte_d   = 8'h00;
        out_valid_d  = 1'b1;
        out_last_d   = final_c && (cnt_d == '0);
        stuff_pend_d = 1'b0;
      end else if (extract) begin
        out_byte_d   = top;
        out_valid_d  = 1'b1;
        out_last_d   = final_c && (cnt_d == '0) && (top != 8'hFF);
        stuff_pend_d = (top == 8'hFF);
      end else begin
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
      end
    end

    // Finished: last byte handed off, or nothing was left to emit at all.
    drained = (out_valid_q && out_last_q && out_ready) ||
              ((cnt_q == '0) && !stuff_pend_q && !out_valid_q);
    done_d  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      RUN:        if (accept && in_flush) state_d = PAD;
      PAD, DRAIN: begin
        if (drained) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default:    state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      stuff_pend_q <= 1'b0;
      out_byte_q   <= 8'h00;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      stuff_pend_q <= stuff_pend_d;
      out_byte_q   <= out_byte_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
    end
  end

  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed + random bench for jpeg_bit_packer; output bytes are collected
// with their last flags and compared against hand values or a bit-level model.
module tb_jpeg_bit_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_code;
  logic [5:0]  in_len;
  logic        in_flush, in_valid, in_ready;
  logic [7:0]  out_byte;
  logic        out_last, out_valid, out_ready, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_cyc = -1;
  int done_cyc = -1;
  bit rnd_mode = 1'b0;
  logic [8:0] outq[$];
  bit bits[$];

  jpeg_bit_packer dut (
    .clk(clk), .rst(rst), .in_code(in_code), .in_len(in_len),
    .in_flush(in_flush), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      outq.push_back({out_last, out_byte});
      if (out_last) last_cyc = cyc;
    end
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(posedge clk) begin
    #2;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [31:0] c, input int l, input bit f);
    bit ok = 1'b0;
    in_code = c; in_len = 6'(l); in_flush = f; in_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #2;
    end
    in_valid = 1'b0; in_flush = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input int maxc);
    int s = done_cnt;
    int k = 0;
    while (done_cnt == s && k < maxc) begin tick(1); k++; end
    if (done_cnt == s) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int dc, c0, nbad;
    logic [31:0] rc, w;
    int rl, ll;
    logic [7:0] b;
    logic [8:0] t;
    logic [8:0] expq[$];

    in_code = '0; in_len = '0; in_flush = 0; in_valid = 0; out_ready = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #2; rst = 0; out_ready = 1;

    // reset mid-stream with 13 bits held
    send(32'h1ABC, 13, 0);
    rst = 1; #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_byte", out_byte, 8'h00);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #2; rst = 0; outq.delete();
    send(32'hA5, 8, 0); tick(4);
    chk("a5_n", outq.size(), 1);
    chk("a5_b0", outq[0], 9'h0A5);

    outq.delete();
    send(32'h5, 3, 0); send(32'h1F, 5, 0); send(32'h0, 0, 0); send(32'h3C, 8, 0); tick(4);
    chk("pack_n", outq.size(), 2);
    chk("pack_b0", outq[0], 9'h0BF);
    chk("pack_b1", outq[1], 9'h03C);

    outq.delete();
    send(32'hFF, 8, 0); send(32'h12, 8, 0); tick(5);
    chk("stuff_n", outq.size(), 3);
    chk("stuff_b0", outq[0], 9'h0FF);
    chk("stuff_b1", outq[1], 9'h000);
    chk("stuff_b2", outq[2], 9'h012);

    outq.delete(); dc = done_cnt;
    send(32'h0, 3, 1); wait_done(50); tick(3);
    chk("pad_n", outq.size(), 1);
    chk("pad_b0", outq[0], 9'h11F);
    chk("pad_done_once", done_cnt - dc, 1);
    chk("pad_done_timing", done_cyc - last_cyc, 1);
    chk("pad_clean_valid", out_valid, 0);
    chk("pad_in_ready", in_ready, 1);

    outq.delete(); dc = done_cnt;
    send(32'h7F, 7, 1); wait_done(50); tick(3);
    chk("padff_n", outq.size(), 2);
    chk("padff_b0", outq[0], 9'h0FF);
    chk("padff_b1", outq[1], 9'h100);
    chk("padff_done_once", done_cnt - dc, 1);

    outq.delete(); dc = done_cnt;
    send(32'h0, 0, 1); c0 = cyc; wait_done(50); tick(3);
    chk("empty_n", outq.size(), 0);
    chk("empty_done_once", done_cnt - dc, 1);
    chk("empty_done_timing", done_cyc - c0, 1);

    // backpressure: output stalled for 12 cycles while four words arrive
    outq.delete(); out_ready = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'hDEADBEEF, 32, 0);
      end
      begin
        int chg = 0;
        bit seen = 0;
        logic [7:0] b0 = 8'h00;
        repeat (12) begin
          @(negedge clk);
          if (out_valid) begin
            if (!seen) begin seen = 1; b0 = out_byte; end
            else if (out_byte != b0) chg++;
          end
        end
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_hold", out_byte, 8'hDE);
        chk("bp_stable", chg, 0);
        @(posedge clk); #2; out_ready = 1;
      end
    join
    tick(40);
    w = 32'hDEADBEEF;
    chk("bp_n", outq.size(), 16);
    for (int i = 0; i < 16; i++) chk("bp_byte", outq[i], {1'b0, w[31 - 8*(i%4) -: 8]});

    // random stream against a bit-queue model
    outq.delete(); bits.delete(); dc = done_cnt; rnd_mode = 1;
    for (int n = 0; n < 10000; n++) begin
      rc = $urandom;
      rl = $urandom_range(0, 36);
      ll = (rl > 32) ? 32 : rl;
      for (int i = ll - 1; i >= 0; i--) bits.push_back(rc[i]);
      send(rc, rl, n == 9999);
    end
    wait_done(5000);
    rnd_mode = 0; out_ready = 1;
    tick(4);
    while (bits.size() % 8 != 0) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i += 8) begin
      b = '0;
      for (int j = 0; j < 8; j++) b = {b[6:0], bits[i + j]};
      expq.push_back({1'b0, b});
      if (b == 8'hFF) expq.push_back(9'h000);
    end
    t = expq.pop_back(); t[8] = 1'b1; expq.push_back(t);
    chk("rand_n", outq.size(), expq.size());
    nbad = 0;
    for (int i = 0; i < expq.size(); i++) if (outq[i] !== expq[i]) nbad++;
    chk("rand_bad", nbad, 0);
    chk("rand_done_once", done_cnt - dc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
